// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues one-at-a-time word requests to imem and buffers {instr, pc} in a FIFO.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall            hold the head entry (decode not consuming)
//   redirect/_pc     execute-stage redirect and its target
//   imem_req/_addr   registered request and word address
//   imem_ack/_rdata  memory response
//   instr_valid      FIFO head valid
//   instr/pc/pc_plus4  head entry (NOP / 0 / 0 when empty)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic            reqNext;
  logic [31:0]     addrNext;
  logic [31:0]     fetchPc;
  logic [31:0]     fetchPcNext;
  logic [31:0]     pendPc;
  logic [31:0]     pendPcNext;

  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   countNext;
  logic [31:0]     instrMem [DEPTH];
  logic [31:0]     pcMem    [DEPTH];
  logic [31:0]     headPc;

  logic            enq;
  logic            deq;
  logic [31:0]     target;
  logic [31:0]     nextAddr;

  assign target      = redirect_pc & ~32'h3;
  assign nextAddr    = imem_addr + 32'd4;
  assign instr_valid = (count != '0);
  assign enq         = (state == REQ) && imem_ack && !redirect;
  assign deq         = instr_valid && !stall && !redirect;
  // Occupancy after this cycle's push/pop; lets a freed slot
  // restart fetch on the very next cycle.
  assign countNext   = count + CW'(enq) - CW'(deq);

  always_comb begin
    stateNext   = state;
    reqNext     = imem_req;
    addrNext    = imem_addr;
    fetchPcNext = fetchPc;
    pendPcNext  = pendPc;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetchPcNext = target;
        end else if (countNext < FULL) begin
          stateNext = REQ;
          reqNext   = 1'b1;
          addrNext  = fetchPc;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            fetchPcNext = target;
            stateNext   = IDLE;
            reqNext     = 1'b0;
          end else begin
            fetchPcNext = nextAddr;
            if (countNext < FULL) begin
              addrNext = nextAddr;
            end else begin
              stateNext = IDLE;
              reqNext   = 1'b0;
            end
          end
        end else if (redirect) begin
          // Old request must still complete; its data is dropped.
          pendPcNext = target;
          stateNext  = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          fetchPcNext = redirect ? target : pendPc;
          stateNext   = IDLE;
          reqNext     = 1'b0;
        end else if (redirect) begin
          pendPcNext = target;
        end
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetchPc   <= RESET_PC;
      pendPc    <= '0;
    end else begin
      state     <= stateNext;
      imem_req  <= reqNext;
      imem_addr <= addrNext;
      fetchPc   <= fetchPcNext;
      pendPc    <= pendPcNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      count <= countNext;
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= imem_addr;
    end
  end

  assign headPc   = pcMem[rdPtr];
  assign instr    = instr_valid ? instrMem[rdPtr] : NOP;
  assign pc       = instr_valid ? headPc : '0;
  assign pc_plus4 = instr_valid ? headPc + 32'd4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue.
// Memory model returns word = address after a programmable wait.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int   lat;
  logic forceAck;
  int   waitCnt;
  int   ackCnt;
  int   addr40Hits;
  int   tests;
  int   fails;
  int   snap;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // ack after `lat` wait cycles of a held request
  assign imem_ack   = imem_req && (forceAck || waitCnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    waitCnt <= (!imem_req || imem_ack) ? 0 : waitCnt + 1;
    if (imem_req && imem_ack) ackCnt <= ackCnt + 1;
    if (imem_req && imem_addr == 32'h40) addr40Hits <= addr40Hits + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    lat = 0;
    forceAck = 1'b0;
    tick; tick; tick;

    // reset state
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0);

    // startup latency and streaming, zero-wait memory
    rst = 1'b0;
    tick;
    chk1("lat_req_c1", imem_req, 1'b1);
    chk("lat_addr_c1", imem_addr, 32'h0);
    chk1("lat_valid_c1", instr_valid, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk1("seq_valid", instr_valid, 1'b1);
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_instr", instr, 32'(4 * i));
      chk("seq_pc4", pc_plus4, 32'(4 * i + 4));
      tick;
    end

    // stall fills the FIFO, release re-arms fetch
    rst = 1'b1;
    stall = 1'b1;
    tick; tick;
    snap = ackCnt;
    rst = 1'b0;
    tick; tick; tick; tick; tick;
    chk1("full_req", imem_req, 1'b0);
    chk1("full_valid", instr_valid, 1'b1);
    chk("full_pc", pc, 32'h0);
    chk("full_acks", 32'(ackCnt - snap), 32'd4);
    tick;
    chk1("full_req_hold", imem_req, 1'b0);
    chk("full_pc_hold", pc, 32'h0);
    stall = 1'b0;
    tick;
    chk1("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h10);
    chk("rel_pc", pc, 32'h4);

    // redirect during a slow request
    rst = 1'b1;
    lat = 2;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("slow_addr_c1", imem_addr, 32'h0);
    tick;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick;
    redirect = 1'b0;
    chk1("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 32'h0);
    chk1("drain_valid", instr_valid, 1'b0);
    tick;
    chk1("drain_done_req", imem_req, 1'b0);
    chk1("drain_done_valid", instr_valid, 1'b0);
    tick;
    chk1("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk1("redir_wait_valid", instr_valid, 1'b0);
      tick;
    end
    chk1("redir_valid", instr_valid, 1'b1);
    chk("redir_pc", pc, 32'h100);
    chk("redir_instr", instr, 32'h100);

    // newest redirect in DRAIN wins
    rst = 1'b1;
    lat = 1000;
    tick; tick;
    rst = 1'b0;
    snap = addr40Hits;
    tick;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick;
    redirect_pc = 32'h80;
    tick;
    redirect = 1'b0;
    chk1("dd_req", imem_req, 1'b1);
    chk("dd_addr", imem_addr, 32'h0);
    forceAck = 1'b1;
    tick;
    forceAck = 1'b0;
    lat = 0;
    chk1("dd_idle_req", imem_req, 1'b0);
    tick;
    chk1("dd_new_req", imem_req, 1'b1);
    chk("dd_new_addr", imem_addr, 32'h80);
    tick;
    chk1("dd_valid", instr_valid, 1'b1);
    chk("dd_pc", pc, 32'h80);
    chk("dd_no40", 32'(addr40Hits - snap), 32'd0);

    // redirect and ack in the same cycle
    chk("sa_addr_before", imem_addr, 32'h84);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick;
    redirect = 1'b0;
    chk1("sa_valid", instr_valid, 1'b0);
    chk("sa_instr", instr, NOP);
    chk1("sa_req", imem_req, 1'b0);
    tick;
    chk1("sa_new_req", imem_req, 1'b1);
    chk("sa_new_addr", imem_addr, 32'h200);

    // reset with two entries buffered and a live request
    stall = 1'b1;
    tick; tick;
    chk1("mr_req", imem_req, 1'b1);
    chk1("mr_valid", instr_valid, 1'b1);
    chk("mr_pc", pc, 32'h200);
    rst = 1'b1;
    tick;
    chk1("mr_rst_req", imem_req, 1'b0);
    chk1("mr_rst_valid", instr_valid, 1'b0);
    chk("mr_rst_instr", instr, NOP);
    rst = 1'b0;
    stall = 1'b0;
    tick;
    chk1("mr_restart_req", imem_req, 1'b1);
    chk("mr_restart_addr", imem_addr, 32'h0);
    tick;
    chk1("mr_restart_valid", instr_valid, 1'b1);
    chk("mr_restart_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the pipelined RISC-V core's IF/ID register. It issues word requests to a variable-latency instruction memory over a req/ack handshake and buffers returned instructions with their PCs in a small FIFO. It presents one instruction per cycle to decode, honours the hazard unit's fetch stall, and flushes on execute-stage redirects (taken branch or jump).

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  StallF from hazard unit; decode does not consume the head entry this cycle.
redirect  in  1  taken branch/jump resolved in execute.
redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
imem_req  out  1  request valid; registered.
imem_addr  out  32  word-aligned request address; registered; stable while imem_req is high.
imem_ack  in  1  response valid; meaningful only while imem_req is high.
imem_rdata  in  32  instruction word; valid with imem_ack.
instr_valid  out  1  the FIFO head is valid.
instr  out  32  head instruction; 32'h00000013 (NOP) when instr_valid is 0.
pc  out  32  head PC; 0 when empty.
pc_plus4  out  32  pc + 4, mod 2^32; 0 when empty.

Behaviour:
- Reset state: fetch_pc = RESET_PC, count = 0, rd/wr pointers = 0, state = IDLE, imem_req = 0, imem_addr = 0, instr_valid = 0.
- Reset applied mid-transaction discards any outstanding request. After rst falls, memory must tolerate imem_req dropping without an ack.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: if count < DEPTH and not redirect, go to REQ with imem_addr = fetch_pc and imem_req = 1. Otherwise stay in IDLE. A redirect in IDLE sets fetch_pc = redirect_pc.
  - REQ: hold imem_req and imem_addr until imem_ack.
    - Ack without redirect: enqueue {imem_rdata, imem_addr}; fetch_pc = imem_addr + 4. If the post-update count < DEPTH, stay in REQ with the new address (back-to-back). Otherwise go to IDLE with imem_req = 0.
    - Ack with redirect in the same cycle: drop the data, flush the FIFO, fetch_pc = redirect_pc, go to IDLE.
    - Redirect without ack: flush the FIFO, latch redirect_pc as the pending target, go to DRAIN. imem_req and imem_addr stay unchanged (the old request completes).
  - DRAIN: keep imem_req high at the old address. On imem_ack, discard the data, set fetch_pc = pending target, go to IDLE. A further redirect in DRAIN overwrites the pending target; the newest redirect wins.
- Only one request is ever outstanding. A request is issued only when count < DEPTH, so the FIFO cannot overflow.
- Dequeue occurs when instr_valid && !stall && !redirect. Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect has priority over everything: the FIFO is cleared in the same cycle and instr_valid = 0 in the next cycle.
- Latency with zero-wait memory:
  - rst falls at cycle 0; imem_req = 1 at cycle 1; ack at cycle 1 gives instr_valid = 1 at cycle 2.
  - Steady state is 1 instruction/cycle.
  - After a redirect with no outstanding request, the first new instruction is valid 3 cycles later.
- Empty FIFO with stall = 1: no effect.
- Full FIFO: imem_req stays 0 until a dequeue, then re-asserts the following cycle.
- Outputs instr, pc and pc_plus4 are driven combinationally from the head entry.

Test Plan:
- Reset, zero-wait memory returning word = address: instr_valid rises 2 cycles after rst falls. Then pc = 0, 4, 8, 12 on consecutive cycles, with instr equal to pc and pc_plus4 = pc + 4.
- stall held high, DEPTH=4: exactly 4 acks are accepted, then imem_req = 0 and the head stays at pc = 0. Releasing stall gives a dequeue and imem_req = 1 the next cycle with imem_addr = 16.
- 3-cycle memory latency, redirect to 32'h00000103 while waiting: imem_addr stays unchanged until ack and the returned data never appears. The next request is 32'h00000100, and instr_valid later shows pc = 32'h100.
- Redirect to 0x40, then redirect to 0x80 while in DRAIN: only the 0x80 path is fetched and 0x40 never reaches imem_addr.
- Redirect and ack in the same cycle: data dropped, FIFO empty the next cycle, next imem_addr = redirect_pc.
- rst asserted while in REQ with 2 entries buffered: next cycle imem_req = 0, instr_valid = 0, instr = 32'h00000013. Fetch restarts at RESET_PC.
